// File: rtl/compare_arbiter_ctrl.sv
// compare_arbiter_ctrl
//
// Two-requester round-robin arbiter in front of a bit-serial magnitude
// comparator. In IDLE the winning requester's operands are captured. SCAN
// then walks them MSB-first, one bit per cycle, and stops early at the first
// differing bit. DONE presents the result for exactly one cycle.
//
// Ports:
//   clock          rising-edge clock for all state
//   reset          asynchronous, active-low reset
//   req[1:0]       request vector, bit i from requester i
//   a0/b0, a1/b1   operands of requester 0 / 1, bits [size:1]
//   gnt[1:0]       registered one-hot grant, 00 when idle
//   busy           high whenever the FSM is not in IDLE
//   done           one-cycle result-valid pulse (DONE state)
//   done_id        requester whose result is on the result outputs
//   a_gt_b/a_lt_b/a_eq_b  registered comparison result, held until next DONE
module compare_arbiter_ctrl #(
  parameter int size = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      req,
  input  logic [size:1]   a0,
  input  logic [size:1]   b0,
  input  logic [size:1]   a1,
  input  logic [size:1]   b1,
  output logic [1:0]      gnt,
  output logic            busy,
  output logic            done,
  output logic            done_id,
  output logic            a_gt_b,
  output logic            a_lt_b,
  output logic            a_eq_b
);

  localparam int kw = $clog2(size + 1);
  localparam logic [kw-1:0] k_init = kw'(size);
  localparam logic [kw-1:0] k_last = kw'(1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [size:1] op_a;
  logic [size:1] op_b;
  logic [kw-1:0] k;
  logic          ptr;
  logic          gnt_id;
  logic          winner;
  logic          bit_diff;

  // Round-robin pick: a lone requester always wins; on contention the
  // requester named by the pointer wins.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ptr;
      default: winner = 1'b0;
    endcase
  end

  assign bit_diff = op_a[k] ^ op_b[k];

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. SCAN exits on the first differing bit or after bit 1.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (bit_diff || (k == k_last)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Datapath: operand capture, grant, pointer, bit index and result regs.
  // Operands and req are only sampled in IDLE, so later input changes or a
  // dropped request cannot disturb an operation already in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt     <= 2'b00;
      gnt_id  <= 1'b0;
      ptr     <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      k       <= k_init;
      done_id <= 1'b0;
      a_gt_b  <= 1'b0;
      a_lt_b  <= 1'b0;
      a_eq_b  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            gnt    <= winner ? 2'b10 : 2'b01;
            gnt_id <= winner;
            ptr    <= ~winner;
            op_a   <= winner ? a1 : a0;
            op_b   <= winner ? b1 : b0;
            k      <= k_init;
          end
        end
        SCAN: begin
          if (bit_diff) begin
            a_gt_b  <= op_a[k];
            a_lt_b  <= ~op_a[k];
            a_eq_b  <= 1'b0;
            done_id <= gnt_id;
          end else if (k == k_last) begin
            a_gt_b  <= 1'b0;
            a_lt_b  <= 1'b0;
            a_eq_b  <= 1'b1;
            done_id <= gnt_id;
          end else begin
            k <= k - k_last;
          end
        end
        DONE: begin
          gnt <= 2'b00;
        end
        default: begin
          gnt <= 2'b00;
        end
      endcase
    end
  end

endmodule
